// File: rtl/rob_recover_pkg.sv
// rob_recover_pkg: shared reorder-buffer definitions.
//   ROB_DEPTH / ROB_N / NUM_FU_CDB : default entry count, dispatch/retire width
//                                    and completion channel count.
//   ROB_IDX                        : index type for the default depth.
//   ROB_ENTRY_PACKET               : per-entry payload; 'complete' marks an
//                                    instruction that needs no later completion.
package rob_recover_pkg;

    localparam int ROB_DEPTH  = 8;
    localparam int ROB_N      = 2;
    localparam int NUM_FU_CDB = 2;

    typedef logic [$clog2(ROB_DEPTH)-1:0] ROB_IDX;

    typedef struct packed {
        logic [15:0] pc;
        logic [5:0]  dest_preg;
        logic [5:0]  old_preg;
        logic        complete;
    } ROB_ENTRY_PACKET;

endpackage

// File: rtl/rob_recover_retire_select.sv
// rob_retire_select: in-order retirement picker.
//   head_i        : index of the oldest entry
//   count_i       : number of live entries
//   valid_i       : per-entry valid vector
//   complete_i    : per-entry complete vector
//   lane_idx_o    : (head+i) mod DEPTH for each retire lane
//   lane_ret_o    : lane i retires this cycle
//   num_retired_o : number of retiring lanes (a prefix of the lanes)
module rob_retire_select
    import rob_recover_pkg::*;
#(
    parameter  int DEPTH = ROB_DEPTH,
    parameter  int N     = ROB_N,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int NR_W  = $clog2(N + 1)
) (
    input  logic [IDX_W-1:0]        head_i,
    input  logic [CNT_W-1:0]        count_i,
    input  logic [DEPTH-1:0]        valid_i,
    input  logic [DEPTH-1:0]        complete_i,
    output logic [N-1:0][IDX_W-1:0] lane_idx_o,
    output logic [N-1:0]            lane_ret_o,
    output logic [NR_W-1:0]         num_retired_o
);

    // Compare-and-subtract wrap so non-power-of-two depths work.
    for (genvar i = 0; i < N; i++) begin : g_lane
        logic [IDX_W:0] sum;
        assign sum = {1'b0, head_i} + (IDX_W+1)'(i);
        assign lane_idx_o[i] = (sum >= (IDX_W+1)'(DEPTH)) ?
                               IDX_W'(sum - (IDX_W+1)'(DEPTH)) : sum[IDX_W-1:0];
    end

    // 'run' drops at the first lane that cannot retire, so retirement
    // is always a contiguous run from the head. The count term keeps
    // stale bits in an empty or short ROB from retiring.
    always_comb begin
        logic run;
        run           = 1'b1;
        lane_ret_o    = '0;
        num_retired_o = '0;
        for (int i = 0; i < N; i++) begin
            run = run && (CNT_W'(i) < count_i) &&
                  valid_i[lane_idx_o[i]] && complete_i[lane_idx_o[i]];
            lane_ret_o[i] = run;
            if (run) num_retired_o = num_retired_o + NR_W'(1);
        end
    end

endmodule

// File: rtl/rob_recover.sv
// rob_recover: N-way reorder buffer with indexed completion and
// single-cycle mispredict rollback.
//   clock, reset         : clock; asynchronous active-low reset
//   wr_data, num_accept  : dispatch packets ([0] oldest) and how many to take
//   alloc_idx            : ROB index (tail+j) mod DEPTH for each dispatch lane
//   cmp_valid, cmp_idx   : completion channels
//   squash, squash_idx   : drop every entry younger than squash_idx
//   retiring_data        : retiring packets ([0] oldest), zero past num_retired
//   num_retired          : entries retiring this cycle
//   free_slots           : DEPTH - count (registered state only)
//   empty, full          : count == 0 / count == DEPTH
module rob_recover
    import rob_recover_pkg::*;
#(
    parameter  int DEPTH = ROB_DEPTH,
    parameter  int N     = ROB_N,
    parameter  int C     = NUM_FU_CDB,
    localparam int IDX_W = $clog2(DEPTH),
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int NA_W  = $clog2(N + 1)
) (
    input  logic                    clock,
    input  logic                    reset,
    input  ROB_ENTRY_PACKET [N-1:0] wr_data,
    input  logic [NA_W-1:0]         num_accept,
    output logic [N-1:0][IDX_W-1:0] alloc_idx,
    input  logic [C-1:0]            cmp_valid,
    input  logic [C-1:0][IDX_W-1:0] cmp_idx,
    input  logic                    squash,
    input  logic [IDX_W-1:0]        squash_idx,
    output ROB_ENTRY_PACKET [N-1:0] retiring_data,
    output logic [NA_W-1:0]         num_retired,
    output logic [CNT_W-1:0]        free_slots,
    output logic                    empty,
    output logic                    full
);

    function automatic logic [IDX_W-1:0] idx_add(input logic [IDX_W-1:0] a,
                                                 input logic [IDX_W:0]   b);
        logic [IDX_W+1:0] s;
        s = {2'b0, a} + {1'b0, b};
        if (s >= (IDX_W+2)'(DEPTH)) s = s - (IDX_W+2)'(DEPTH);
        return s[IDX_W-1:0];
    endfunction

    // Distance of entry e from the head, i.e. its age rank (0 = oldest).
    function automatic logic [IDX_W-1:0] age_of(input logic [IDX_W-1:0] e,
                                                input logic [IDX_W-1:0] h);
        logic [IDX_W:0] d;
        if (e >= h) d = {1'b0, e} - {1'b0, h};
        else        d = {1'b0, e} + (IDX_W+1)'(DEPTH) - {1'b0, h};
        return d[IDX_W-1:0];
    endfunction

    ROB_ENTRY_PACKET  pkt_q [DEPTH];
    ROB_ENTRY_PACKET  pkt_d [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [DEPTH-1:0] complete_q, complete_d;
    logic [IDX_W-1:0] head_q, head_d;
    logic [IDX_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [N-1:0][IDX_W-1:0] lane_idx;
    logic [N-1:0]            lane_ret;
    logic [IDX_W-1:0]        sq_age;
    logic [DEPTH-1:0]        sq_mask;

    rob_retire_select #(.DEPTH(DEPTH), .N(N)) u_sel (
        .head_i        (head_q),
        .count_i       (count_q),
        .valid_i       (valid_q),
        .complete_i    (complete_q),
        .lane_idx_o    (lane_idx),
        .lane_ret_o    (lane_ret),
        .num_retired_o (num_retired)
    );

    for (genvar j = 0; j < N; j++) begin : g_alloc
        assign alloc_idx[j] = idx_add(tail_q, (IDX_W+1)'(j));
    end

    // Squash mask: live entries whose age rank is beyond the branch's.
    // Comparing ages rather than raw indices makes the wrap case free.
    assign sq_age = age_of(squash_idx, head_q);

    always_comb begin
        logic [IDX_W-1:0] a;
        sq_mask = '0;
        for (int e = 0; e < DEPTH; e++) begin
            a = age_of(IDX_W'(e), head_q);
            sq_mask[e] = squash && (a > sq_age) && (CNT_W'(a) < count_q);
        end
    end

    always_comb begin
        pkt_d      = pkt_q;
        valid_d    = valid_q;
        complete_d = complete_q;
        // Completions land only on live entries that survive a same-cycle squash.
        for (int k = 0; k < C; k++) begin
            if (cmp_valid[k] && valid_q[cmp_idx[k]] && !sq_mask[cmp_idx[k]])
                complete_d[cmp_idx[k]] = 1'b1;
        end
        if (squash) begin
            valid_d    = valid_d & ~sq_mask;
            complete_d = complete_d & ~sq_mask;
        end else begin
            for (int j = 0; j < N; j++) begin
                if (NA_W'(j) < num_accept) begin
                    pkt_d[alloc_idx[j]]      = wr_data[j];
                    valid_d[alloc_idx[j]]    = 1'b1;
                    complete_d[alloc_idx[j]] = wr_data[j].complete;
                end
            end
        end
        for (int i = 0; i < N; i++) begin
            if (lane_ret[i]) begin
                valid_d[lane_idx[i]]    = 1'b0;
                complete_d[lane_idx[i]] = 1'b0;
            end
        end
    end

    always_comb begin
        logic [CNT_W-1:0] base;
        base    = squash ? CNT_W'(sq_age) + CNT_W'(1) : count_q;
        count_d = base - CNT_W'(num_retired) + (squash ? '0 : CNT_W'(num_accept));
        head_d  = idx_add(head_q, (IDX_W+1)'(num_retired));
        tail_d  = squash ? idx_add(squash_idx, (IDX_W+1)'(1))
                         : idx_add(tail_q, (IDX_W+1)'(num_accept));
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int e = 0; e < DEPTH; e++) pkt_q[e] <= '0;
            valid_q    <= '0;
            complete_q <= '0;
            head_q     <= '0;
            tail_q     <= '0;
            count_q    <= '0;
        end else begin
            pkt_q      <= pkt_d;
            valid_q    <= valid_d;
            complete_q <= complete_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            count_q    <= count_d;
        end
    end

    always_comb begin
        ROB_ENTRY_PACKET p;
        for (int i = 0; i < N; i++) begin
            p          = pkt_q[lane_idx[i]];
            p.complete = complete_q[lane_idx[i]];
            retiring_data[i] = lane_ret[i] ? p : '0;
        end
    end

    assign free_slots = CNT_W'(DEPTH) - count_q;
    assign empty      = (count_q == '0);
    assign full       = (count_q == CNT_W'(DEPTH));

    a_no_overflow: assert property (@(posedge clock) disable iff (!reset)
        !squash |-> (CNT_W'(num_accept) <= free_slots));
    a_squash_live: assert property (@(posedge clock) disable iff (!reset)
        squash |-> (CNT_W'(sq_age) < count_q));

endmodule

// File: tb/tb_rob_recover.sv
module tb_rob_recover;
    import rob_recover_pkg::*;

    localparam int D = 8, NW = 2, CW = 2, IW = 3, CNTW = 4, NAW = 2;

    logic                   clock = 1'b0;
    logic                   reset;
    ROB_ENTRY_PACKET [NW-1:0] wr_data;
    logic [NAW-1:0]         num_accept;
    logic [NW-1:0][IW-1:0]  alloc_idx;
    logic [CW-1:0]          cmp_valid;
    logic [CW-1:0][IW-1:0]  cmp_idx;
    logic                   squash;
    logic [IW-1:0]          squash_idx;
    ROB_ENTRY_PACKET [NW-1:0] retiring_data;
    logic [NAW-1:0]         num_retired;
    logic [CNTW-1:0]        free_slots;
    logic                   empty, full;

    rob_recover #(.DEPTH(D), .N(NW), .C(CW)) dut (
        .clock(clock), .reset(reset), .wr_data(wr_data), .num_accept(num_accept),
        .alloc_idx(alloc_idx), .cmp_valid(cmp_valid), .cmp_idx(cmp_idx),
        .squash(squash), .squash_idx(squash_idx), .retiring_data(retiring_data),
        .num_retired(num_retired), .free_slots(free_slots), .empty(empty), .full(full)
    );

    always #5 clock = ~clock;

    // Reference: the ROB as an oldest-first queue of live entries.
    typedef struct {
        int              idx;
        ROB_ENTRY_PACKET pkt;
        bit              done;
    } ment_t;

    ment_t mq[$];
    int    m_tail;
    int    n_chk  = 0;
    int    n_pass = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic int exp_nr();
        int n = 0;
        while (n < NW && n < mq.size() && mq[n].done) n++;
        return n;
    endfunction

    task automatic compare_all();
        int nr = exp_nr();
        ROB_ENTRY_PACKET e;
        chk("num_retired", 64'(num_retired), 64'(nr));
        chk("free_slots", 64'(free_slots), 64'(D - mq.size()));
        chk("empty", 64'(empty), 64'(mq.size() == 0));
        chk("full", 64'(full), 64'(mq.size() == D));
        for (int j = 0; j < NW; j++)
            chk($sformatf("alloc_idx[%0d]", j), 64'(alloc_idx[j]), 64'((m_tail + j) % D));
        for (int i = 0; i < NW; i++) begin
            e = '0;
            if (i < nr) begin
                e = mq[i].pkt;
                e.complete = 1'b1;
            end
            chk($sformatf("retiring_data[%0d]", i), 64'(retiring_data[i]), 64'(e));
        end
    endtask

    task automatic model_update();
        int nr = exp_nr();
        int p;
        ment_t m;
        if (squash) begin
            p = -1;
            foreach (mq[i]) if (mq[i].idx == int'(squash_idx)) p = i;
            while (mq.size() > p + 1) void'(mq.pop_back());
            m_tail = (int'(squash_idx) + 1) % D;
        end
        for (int k = 0; k < CW; k++)
            if (cmp_valid[k])
                foreach (mq[i]) if (mq[i].idx == int'(cmp_idx[k])) mq[i].done = 1'b1;
        repeat (nr) void'(mq.pop_front());
        if (!squash) begin
            for (int j = 0; j < int'(num_accept); j++) begin
                m.idx  = (m_tail + j) % D;
                m.pkt  = wr_data[j];
                m.done = wr_data[j].complete;
                mq.push_back(m);
            end
            m_tail = (m_tail + int'(num_accept)) % D;
        end
    endtask

    task automatic run_cycle();
        @(negedge clock);
        compare_all();
        @(posedge clock);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        num_accept = '0;
        wr_data    = '0;
        cmp_valid  = '0;
        cmp_idx    = '0;
        squash     = 1'b0;
        squash_idx = '0;
    endtask

    task automatic set_disp(input int na, input bit c);
        num_accept = NAW'(na);
        for (int j = 0; j < NW; j++) begin
            wr_data[j].pc        = 16'($urandom);
            wr_data[j].dest_preg = 6'($urandom);
            wr_data[j].old_preg  = 6'($urandom);
            wr_data[j].complete  = c;
        end
    endtask

    task automatic rand_inputs();
        int sz = mq.size();
        int nr = exp_nr();
        int maxa, lo, p;
        set_idle();
        maxa = D - sz;
        if (maxa > NW) maxa = NW;
        set_disp($urandom_range(maxa, 0), 1'b0);
        for (int j = 0; j < NW; j++) wr_data[j].complete = ($urandom_range(3, 0) == 0);
        for (int k = 0; k < CW; k++) begin
            cmp_valid[k] = 1'($urandom_range(1, 0));
            if (sz > 0 && $urandom_range(9, 0) < 7) cmp_idx[k] = IW'(mq[$urandom_range(sz - 1, 0)].idx);
            else                                    cmp_idx[k] = IW'($urandom_range(D - 1, 0));
        end
        // Squash only a live entry at or younger than anything retiring now.
        if (sz > 0 && $urandom_range(9, 0) == 0) begin
            lo = (nr > 0) ? nr - 1 : 0;
            p  = $urandom_range(sz - 1, lo);
            squash     = 1'b1;
            squash_idx = IW'(mq[p].idx);
        end
    endtask

    task automatic do_reset_check(input string tag);
        set_idle();
        #2 reset = 1'b0;
        #1;
        chk({tag, "_empty"}, 64'(empty), 64'(1));
        chk({tag, "_free"}, 64'(free_slots), 64'(8));
        chk({tag, "_full"}, 64'(full), 64'(0));
        chk({tag, "_nret"}, 64'(num_retired), 64'(0));
        chk({tag, "_alloc0"}, 64'(alloc_idx[0]), 64'(0));
        chk({tag, "_alloc1"}, 64'(alloc_idx[1]), 64'(1));
        mq.delete();
        m_tail = 0;
        @(negedge clock);
        reset = 1'b1;
        @(posedge clock);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not end in time");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        set_idle();
        @(posedge clock);
        #1;
        do_reset_check("reset");

        // Fill: 2 per cycle x4.
        for (int c = 0; c < 4; c++) begin
            set_idle(); set_disp(2, 1'b0); run_cycle();
        end
        chk("fill_full", 64'(full), 64'(1));
        chk("fill_free", 64'(free_slots), 64'(0));

        // Complete 0 and 1, retire next cycle, slots free the cycle after.
        set_idle(); cmp_valid = 2'b11; cmp_idx[0] = 3'd0; cmp_idx[1] = 3'd1; run_cycle();
        chk("cmp01_nret", 64'(num_retired), 64'(2));
        set_idle(); run_cycle();
        chk("cmp01_free", 64'(free_slots), 64'(2));

        // head=2, tail=0: squash at 3 with dispatch ignored.
        set_idle(); set_disp(2, 1'b1); squash = 1'b1; squash_idx = 3'd3; run_cycle();
        chk("sq_tail", 64'(alloc_idx[0]), 64'(4));
        chk("sq_free", 64'(free_slots), 64'(6));

        // Both channels hit idx 3 while it retires.
        set_idle(); cmp_valid = 2'b11; cmp_idx[0] = 3'd2; cmp_idx[1] = 3'd3; run_cycle();
        chk("dup_nret", 64'(num_retired), 64'(2));
        set_idle(); cmp_valid = 2'b11; cmp_idx[0] = 3'd3; cmp_idx[1] = 3'd3; run_cycle();
        chk("dup_empty", 64'(empty), 64'(1));
        chk("dup_free", 64'(free_slots), 64'(8));

        // Wrap: head=4, entries 4..7,0; squash 7 and complete 0 together.
        set_idle(); set_disp(2, 1'b0); run_cycle();
        set_idle(); set_disp(2, 1'b0); run_cycle();
        set_idle(); set_disp(1, 1'b0); run_cycle();
        set_idle(); set_disp(2, 1'b0); squash = 1'b1; squash_idx = 3'd7;
        cmp_valid = 2'b01; cmp_idx[0] = 3'd0; run_cycle();
        chk("wrap_tail", 64'(alloc_idx[0]), 64'(0));
        chk("wrap_free", 64'(free_slots), 64'(4));
        set_idle(); set_disp(1, 1'b0); run_cycle();
        chk("pre_rst_free", 64'(free_slots), 64'(3));
        do_reset_check("midrst");

        for (int c = 0; c < 600; c++) begin
            if (c == 300) do_reset_check("randrst");
            rand_inputs();
            run_cycle();
        end

        set_idle();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/rob_recover.md
# rob_recover

Parametrised N-way reorder buffer with index-addressed completion and branch-mispredict rollback. Sits between dispatch and retirement in the R10K pipeline. It allocates up to N entries per cycle at the tail and returns their ROB indices. It marks entries complete from C functional-unit channels, retires up to N completed entries in order from the head, and on mispredict truncates every entry younger than the branch in one cycle.

## Interface
- DEPTH, `PHYS_REG_SZ_R10K: entry count; any value ≥ 2·N; power of two not required.
- N, `N: dispatch and retire width.
- C, `NUM_FU_CDB: completion channels per cycle.
- clock  in  1  single clock; all state updates on posedge.
- reset  in  1  asynchronous, active-low; asserting clears all state immediately.
- wr_data  in  N×ROB_ENTRY_PACKET  dispatch packets; [0] oldest.
- num_accept  in  $clog2(N+1)  entries to allocate; must be ≤ min(N, free_slots).
- alloc_idx  out  N×ROB_IDX  indices (tail+j) mod DEPTH for lanes j < num_accept.
- cmp_valid  in  C  completion channel valid.
- cmp_idx  in  C×ROB_IDX  ROB index being completed.
- squash  in  1  mispredict recovery request.
- squash_idx  in  ROB_IDX  index of mispredicted branch; the branch itself is kept.
- retiring_data  out  N×ROB_ENTRY_PACKET  retiring entries; [0] oldest; lanes ≥ num_retired are zero.
- num_retired  out  $clog2(N+1)  entries retiring this cycle.
- free_slots  out  $clog2(DEPTH+1)  DEPTH − count, from registered state only.
- empty, full  out  1  count==0 and count==DEPTH.

## Operation
- State: head, tail (ROB_IDX) and count ($clog2(DEPTH+1)). Per entry: packet, valid, complete. count resolves the head==tail ambiguity.
- Index arithmetic: (a+b) mod DEPTH via compare-and-subtract. No reliance on natural wrap.
- Retire (combinational):
  - Lane i retires iff lanes 0..i−1 retire, entry (head+i) is valid and complete, and i < count.
  - retiring_data[i] = entry (head+i).
  - Stops at the first incomplete entry.
- Complete: each cmp_valid[k] sets complete on cmp_idx[k] if that entry is valid.
  - Duplicate indices across channels are legal.
  - Completion to an invalid entry is ignored.
  - Completion to an entry squashed the same cycle is dropped.
- Dispatch (no squash): lanes j < num_accept write wr_data[j] to (tail+j), with valid=1 and complete=wr_data[j].complete.
  - tail += num_accept.
- Squash: squash_idx must be a live entry.
  - Entries strictly younger than squash_idx, up to tail−1, get valid=0 and complete=0.
  - tail ← squash_idx+1. Dispatch is ignored that cycle.
  - Retirement still proceeds the same cycle; retired lanes can only be at or older than squash_idx.
- Next state:
  - count' = count − num_retired + (squash ? 0 : num_accept), with squash first truncating count to ((squash_idx − head) mod DEPTH) + 1.
  - head' = head + num_retired.
  - Retired entries get valid=0.

## Timing
- Reset values:
  - head=tail=count=0; all valid and complete = 0.
  - num_retired=0, retiring_data=0, free_slots=DEPTH, empty=1, full=0.
  - alloc_idx lanes = 0..N−1.
- Dispatch to earliest retire: 1 cycle if dispatched already complete, otherwise 1 cycle after the completion edge.
- Completion to visible retire: the complete bit is registered, so retire happens in the cycle after cmp_valid.
- free_slots excludes same-cycle retirement. This avoids a dispatch↔retire combinational loop; a full ROB accepts only in the next cycle.
- Full: with num_accept > free_slots, behaviour is undefined and flagged by an assertion.
- Empty: num_retired = 0 regardless of stale bits.
- Wrap-around: allocation, retirement and the squash younger-range all span index DEPTH−1 → 0 correctly.
- Reset mid-operation: all state returns to reset values asynchronously. The first update after reset deassertion is the next posedge.

## Structure
- The shared sys_defs package holds:
  - ROB_ENTRY_PACKET (existing; complete field reused).
  - typedef ROB_IDX = logic [$clog2(DEPTH)−1:0].
  - `NUM_FU_CDB.
- Sub-module rob_retire_select: takes head, count and the valid/complete vectors; outputs num_retired and the per-lane entry indices.
- The top level holds storage, the head/tail/count registers, and the squash mask, built as an age compare relative to head.

## Test plan
- DEPTH=8, N=2, C=2: reset low mid-run with count=5 → immediately count=0, empty=1, free_slots=8, num_retired=0.
- Dispatch 2/cycle ×4 → full=1 and free_slots=0. Complete idx 0,1 → next cycle num_retired=2; free_slots=2 the cycle after.
- head=6, tail=2 (count 4): complete idx 7 only → num_retired=0. Then complete 6 → next cycle 2 retire, with retiring_data from idx 6 and 7.
- head=2, tail=7: squash_idx=3 with num_accept=2 → tail=4, count=2, entries 4–6 invalid, no allocation.
- head=5, tail=1 (wrap): squash_idx=7 plus completion to idx 0 the same cycle → idx 0 stays invalid, tail=0, count=3.
- Both channels complete idx 3, and idx 3 is retiring the same cycle → single retire, no double count, count decrements by exactly 1.
